// File: rtl/div_pkg.sv
// Shared definitions for the divider datapath and its BCD display converter.
package div_pkg;

  localparam int unsigned DIV_WIDTH  = 27;
  localparam int unsigned BCD_DIGITS = 9;

  typedef enum logic [1:0] {
    e_idle,
    e_op,
    e_done
  } t_b2b_state;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a digit >= 5 gets +3 so the following
// left shift carries correctly into the next decimal digit.
module bcd_adj3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). One input bit is consumed
// per cycle; start/ready/done handshake matches the divider so the divider's
// done can drive i_start directly.
module bin2bcd_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int unsigned BcdW = 4 * DIGITS;
  // Holds the value WIDTH, so a down-count from WIDTH never wraps.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  t_b2b_state        state_q, state_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [BcdW-1:0]   bcd_adj;

  // Per-digit +3 correction applied before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // Next-state: load on accepted start, shift one bit per OP cycle.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      e_idle: begin
        if (i_start) begin
          shift_d = i_bin;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CntW'(WIDTH);
          state_d = e_op;
        end
      end
      e_op: begin
        // Shift {bcd, shift} left by one; the adjusted top digit's MSB
        // leaves the register and marks an out-of-range value.
        bcd_d   = {bcd_adj[BcdW-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        ovf_d   = ovf_q | bcd_adj[BcdW-1];
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = e_done;
        end
      end
      e_done: begin
        state_d = e_idle;
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= e_idle;
      bcd_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ready = (state_q == e_idle);
  assign o_done  = (state_q == e_done);
  assign o_bcd   = bcd_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a default 27-bit/9-digit instance fed
// through a scoreboard, plus an 8-bit/2-digit instance for overflow cases.
module tb_bin2bcd_seq;

  localparam int W  = 27;
  localparam int D  = 9;
  localparam int NW = 8;
  localparam int ND = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst;
  logic            i_start;
  logic [W-1:0]    i_bin;
  logic            o_ready;
  logic            o_done;
  logic [4*D-1:0]  o_bcd;
  logic            o_ovf;

  logic            n_start;
  logic [NW-1:0]   n_bin;
  logic            n_ready;
  logic            n_done;
  logic [4*ND-1:0] n_bcd;
  logic            n_ovf;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) u_dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_ready (o_ready),
    .o_done  (o_done),
    .o_bcd   (o_bcd),
    .o_ovf   (o_ovf)
  );

  bin2bcd_seq #(.WIDTH(NW), .DIGITS(ND)) u_narrow (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (n_start),
    .i_bin   (n_bin),
    .o_ready (n_ready),
    .o_done  (n_done),
    .o_bcd   (n_bcd),
    .o_ovf   (n_ovf)
  );

  typedef struct {
    logic [4*D-1:0] bcd;
    logic           ovf;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   dones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Scoreboard monitor: every done pops one expectation. Latency is counted
  // as the number of edges from the accept edge to the edge that sees done.
  always @(negedge clk) begin
    if (!i_rst && o_done) begin
      exp_t e;
      dones++;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_done observed=done expected=no_done");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bcd", 64'(o_bcd), 64'(e.bcd));
        chk("ovf", 64'(o_ovf), 64'(e.ovf));
        chk("latency", 64'(cyc - e.acc + 1), 64'(W + 1));
      end
    end
  end

  task automatic start_conv(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic eo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(o_ready), 64'(1));
    i_start = 1'b1;
    i_bin   = v;
    e.bcd = eb;
    e.ovf = eo;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic narrow_conv(input logic [NW-1:0] v, input logic [4*ND-1:0] eb, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!n_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_start = 1'b1;
    n_bin   = v;
    @(negedge clk);
    n_start = 1'b0;
    n = 0;
    while (!n_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("n_done", 64'(n_done), 64'(1));
    chk("n_bcd", 64'(n_bcd), 64'(eb));
    chk("n_ovf", 64'(n_ovf), 64'(eo));
  endtask

  initial begin
    exp_t e;
    int   c;
    int   d0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_bin   = '0;
    n_start = 1'b0;
    n_bin   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'(1));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_bcd", 64'(o_bcd), 64'(0));
    chk("rst_ovf", 64'(o_ovf), 64'(0));
    i_rst = 1'b0;

    // Zero input: full latency, all-zero digits.
    start_conv(27'd0, 36'h000000000, 1'b0);
    wait_drain();

    // Directed values, including the largest 27-bit input.
    start_conv(27'd12345678, 36'h012345678, 1'b0);
    start_conv(27'h7FFFFFF, 36'h134217727, 1'b0);
    start_conv(27'd1, to_bcd(1), 1'b0);
    start_conv(27'd99999999, to_bcd(99999999), 1'b0);
    start_conv(27'd100000000, to_bcd(100000000), 1'b0);
    start_conv(27'd142, 36'h000000142, 1'b0);
    wait_drain();

    // Start while busy is ignored.
    start_conv(27'd500, 36'h000000500, 1'b0);
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    i_bin   = 27'd7;
    @(negedge clk);
    i_start = 1'b0;
    wait_drain();
    chk("no_requeue_ready", 64'(o_ready), 64'(1));

    // Reset 10 cycles into a conversion aborts it.
    start_conv(27'd123, to_bcd(123), 1'b0);
    repeat (9) @(negedge clk);
    i_rst = 1'b1;
    sb.delete();
    @(negedge clk);
    i_rst = 1'b0;
    chk("abort_ready", 64'(o_ready), 64'(1));
    chk("abort_bcd", 64'(o_bcd), 64'(0));
    chk("abort_ovf", 64'(o_ovf), 64'(0));
    d0 = dones;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(dones), 64'(d0));

    // Start held high: back-to-back conversions every WIDTH+2 cycles.
    i_bin   = 27'd42;
    i_start = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.bcd = 36'h000000042;
      e.ovf = 1'b0;
      e.acc = c + 1 + k * (W + 2);
      sb.push_back(e);
    end
    wait_drain();
    i_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("tied_high_count", 64'(sb.size()), 64'(0));

    // Narrow instance: overflow keeps the low digits.
    narrow_conv(8'd255, 8'h55, 1'b1);
    narrow_conv(8'd99, 8'h99, 1'b0);
    narrow_conv(8'd100, 8'h00, 1'b1);
    narrow_conv(8'd7, 8'h07, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
